// File: rtl/vesa_timing_align.sv
// VESA raster timing generator that re-aligns hs/vs/de to pixels returned by the image cache.
// Optional colour-bar generator is built when VESA_TEST_PATTERN_EN is defined.
module vesa_timing_align #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned H_FP       = 88,
  parameter int unsigned H_SYNC     = 44,
  parameter int unsigned H_BP       = 148,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 36,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VESA_TEST_PATTERN_EN
  input  logic        pattern_en,
`endif
  output logic        vesa_vsync,
  output logic        vesa_de,
  input  logic        pix_de_in,
  input  logic [15:0] pix_data_in,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic        hdmi_de,
  output logic [23:0] hdmi_rgb,
  output logic        align_err
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  h_last;
  logic                  v_last;
  logic                  de_raw;
  logic                  hs_raw;
  logic                  vs_raw;
  logic [RD_LATENCY-1:0] de_sr;
  logic [RD_LATENCY-1:0] hs_sr;
  logic [RD_LATENCY-1:0] vs_sr;
  logic                  de_d;
  logic                  hs_d;
  logic                  vs_d;
  logic [23:0]           rgb_c;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  assign h_last = (32'(h_cnt) == H_TOTAL - 1);
  assign v_last = (32'(v_cnt) == V_TOTAL - 1);

  // Raster counters; v advances on the same edge h wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Raw timing decode, one clk behind the counters; also the cache request strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      de_raw <= 1'b0;
      hs_raw <= 1'b0;
      vs_raw <= 1'b0;
    end else begin
      de_raw <= (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
      hs_raw <= (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
      vs_raw <= (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    end
  end

  assign vesa_de    = de_raw;
  assign vesa_vsync = vs_raw;

  // Delay line matching the cache read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= RD_LATENCY'({de_sr, de_raw});
      hs_sr <= RD_LATENCY'({hs_sr, hs_raw});
      vs_sr <= RD_LATENCY'({vs_sr, vs_raw});
    end
  end

  assign de_d = de_sr[RD_LATENCY-1];
  assign hs_d = hs_sr[RD_LATENCY-1];
  assign vs_d = vs_sr[RD_LATENCY-1];

`ifdef VESA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [HW-1:0]         col_raw;
  logic [HW-1:0]         col_sr [RD_LATENCY];
  logic                  pat_raw;
  logic [RD_LATENCY-1:0] pat_sr;
  logic [2:0]            bar;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Column and frame-latched pattern select travel with de_raw through the delay line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_raw <= '0;
      pat_raw <= 1'b0;
      pat_sr  <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) col_sr[i] <= '0;
    end else begin
      col_raw <= h_cnt;
      if ((h_cnt == '0) && (v_cnt == '0)) pat_raw <= pattern_en;
      pat_sr    <= RD_LATENCY'({pat_sr, pat_raw});
      col_sr[0] <= col_raw;
      for (int i = 1; i < int'(RD_LATENCY); i++) col_sr[i] <= col_sr[i-1];
    end
  end

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(col_sr[RD_LATENCY-1]) >= 32'(i) * BAR_W) bar = 3'(i);
    end
    rgb_c = pat_sr[RD_LATENCY-1] ? bar_color(bar) : rgb565_to_888(pix_data_in);
  end
`else
  assign rgb_c = rgb565_to_888(pix_data_in);
`endif

  // Output stage; syncs drive their POL level while asserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdmi_hs   <= !HS_POL;
      hdmi_vs   <= !VS_POL;
      hdmi_de   <= 1'b0;
      hdmi_rgb  <= '0;
      align_err <= 1'b0;
    end else begin
      hdmi_hs   <= hs_d ~^ HS_POL;
      hdmi_vs   <= vs_d ~^ VS_POL;
      hdmi_de   <= de_d;
      hdmi_rgb  <= de_d ? rgb_c : 24'h0;
      align_err <= align_err | (de_d != pix_de_in);
    end
  end

endmodule

// File: tb/tb_vesa_timing_align.sv
// Randomized bench for vesa_timing_align on a 14x7 raster with a cache echo model.
module tb_vesa_timing_align;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_de_in = 1'b0;
  logic [15:0] pix_data_in = 16'h0;
  logic        vesa_vsync, vesa_de, hdmi_hs, hdmi_vs, hdmi_de, align_err;
  logic [23:0] hdmi_rgb;

  vesa_timing_align #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .vesa_vsync(vesa_vsync), .vesa_de(vesa_de),
    .pix_de_in(pix_de_in), .pix_data_in(pix_data_in),
    .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de),
    .hdmi_rgb(hdmi_rgb), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n = 0;
  int          echo_dly = LAT;
  bit          de_hist[$];
  logic [15:0] data_prev = 16'h0;
  bit          pde_prev = 1'b0;
  bit          err_exp = 1'b0;
  int          hs_cnt = 0;
  int          vs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Reference raster: position p counts clocks since the frame started at (0,0).
  function automatic bit m_de(input int p);
    int q;
    q = (p < 0) ? 0 : p % FT;
    return (p >= 0) && (q % HT < HA) && (q / HT < VA);
  endfunction

  function automatic bit m_hs(input int p);
    int h;
    h = (p < 0) ? 0 : (p % FT) % HT;
    return (p >= 0) && (h >= HA + HF) && (h < HA + HF + HS);
  endfunction

  function automatic bit m_vs(input int p);
    int v;
    v = (p < 0) ? 0 : (p % FT) / HT;
    return (p >= 0) && (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  function automatic logic [23:0] exp565(input logic [15:0] d);
    logic [7:0] r, g, b;
    r = {d[15:11], 3'b000} | {5'b0, d[15:13]};
    g = {d[10:5], 2'b00} | {6'b0, d[10:9]};
    b = {d[4:0], 3'b000} | {5'b0, d[4:2]};
    return {r, g, b};
  endfunction

  // One clock: check outputs against the model, then drive the cache echo for the next clk.
  task automatic step();
    bit          rst_edge;
    logic [23:0] rgb_exp;
    int          r;
    @(posedge clk);
    #1;
    rst_edge = !rst;
    if (rst_edge) begin
      n = 0;
      err_exp = 1'b0;
      de_hist.delete();
    end else begin
      n++;
      if (m_de(n - 4) != pde_prev) err_exp = 1'b1;
    end
    rgb_exp = m_de(n - 4) ? exp565(data_prev) : 24'h0;
    chk("vesa_de", 32'(vesa_de), 32'(m_de(n - 1)));
    chk("vesa_vsync", 32'(vesa_vsync), 32'(m_vs(n - 1)));
    chk("hdmi_de", 32'(hdmi_de), 32'(m_de(n - 4)));
    chk("hdmi_hs", 32'(hdmi_hs), 32'(m_hs(n - 4)));
    chk("hdmi_vs", 32'(hdmi_vs), 32'(m_vs(n - 4)));
    chk("hdmi_rgb", 32'(hdmi_rgb), 32'(rgb_exp));
    chk("align_err", 32'(align_err), 32'(err_exp));
    if (n >= 10 && n < 10 + FT) begin
      if (hdmi_hs) hs_cnt++;
      if (hdmi_vs) vs_cnt++;
    end
    de_hist.push_front(vesa_de);
    pde_prev = (de_hist.size() > echo_dly) ? de_hist[echo_dly] : 1'b0;
    r = int'($urandom_range(0, 9));
    data_prev = (r < 2) ? 16'hF800 : (r < 4) ? 16'h07E0 : 16'($urandom);
    pix_de_in = pde_prev;
    pix_data_in = data_prev;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b1;
    repeat (2 * FT + 20) step();
    chk("hs_per_frame", 32'(hs_cnt), 32'(VT * HS));
    chk("vs_per_frame", 32'(vs_cnt), 32'(HT * VS));

    // Single-clock reset while the counters sit at h=5, v=2.
    for (int i = 0; i < FT && (n % FT) != 2 * HT + 5; i++) step();
    rst = 1'b0;
    step();
    chk("midreset_n", 32'(n), 32'(0));
    rst = 1'b1;
    step();
    chk("rise_after_release", 32'(vesa_de), 32'(1));
    repeat (2 * FT) step();

    // Random-length runs with random-length resets.
    repeat (4) begin
      repeat ($urandom_range(5, 150)) step();
      rst = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      rst = 1'b1;
    end
    repeat (FT) step();

    // Cache answers one clock late: error must latch within the first line and hold.
    echo_dly = LAT + 1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (HT) step();
    chk("align_err_set", 32'(align_err), 32'(1));
    repeat (FT) step();
    chk("align_err_sticky", 32'(align_err), 32'(1));
    echo_dly = LAT;
    rst = 1'b0;
    step();
    chk("align_err_clear", 32'(align_err), 32'(0));
    rst = 1'b1;
    repeat (FT) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
